// File: rtl/f_reg_file_sb.sv
// Floating-point register file: two write ports, three async read ports with optional
// same-edge forwarding, a busy scoreboard for long-latency ops and accrued fflags.

module f_reg_file_sb_rdport #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 5,
    parameter int REG_COUNT  = 2**ADDR_WIDTH,
    parameter bit BYPASS     = 1'b1
) (
    input  logic [ADDR_WIDTH-1:0]                 rd_addr_i,
    input  logic [REG_COUNT-1:0][DATA_WIDTH-1:0]  regs_i,
    input  logic [REG_COUNT-1:0]                  busy_i,
    input  logic                                  we_a_i,
    input  logic [ADDR_WIDTH-1:0]                 addr_a_i,
    input  logic [DATA_WIDTH-1:0]                 data_a_i,
    input  logic                                  we_b_i,
    input  logic [ADDR_WIDTH-1:0]                 addr_b_i,
    input  logic [DATA_WIDTH-1:0]                 data_b_i,
    output logic [DATA_WIDTH-1:0]                 data_o,
    output logic                                  busy_o
);
    logic hit_a, hit_b;

    assign hit_a = BYPASS && we_a_i && (addr_a_i == rd_addr_i);
    assign hit_b = BYPASS && we_b_i && (addr_b_i == rd_addr_i);

    always_comb begin
        data_o = regs_i[rd_addr_i];
        if (hit_a)
            data_o = data_a_i;
        else if (hit_b)
            data_o = data_b_i;
    end

    // A forwarded port-B result means the consumer no longer has to wait.
    assign busy_o = busy_i[rd_addr_i] & ~hit_b;
endmodule

module f_reg_file_sb #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 5,
    parameter bit BYPASS     = 1'b1,
    parameter int FLAG_WIDTH = 5
) (
    input  logic                  CLK,
    input  logic                  RESET,
    input  logic                  WRITE_EN_A,
    input  logic [ADDR_WIDTH-1:0] IN_ADDRESS_A,
    input  logic [DATA_WIDTH-1:0] DATA_IN_A,
    input  logic [FLAG_WIDTH-1:0] FLAGS_A,
    input  logic                  WRITE_EN_B,
    input  logic [ADDR_WIDTH-1:0] IN_ADDRESS_B,
    input  logic [DATA_WIDTH-1:0] DATA_IN_B,
    input  logic [FLAG_WIDTH-1:0] FLAGS_B,
    input  logic                  ISSUE_EN,
    input  logic [ADDR_WIDTH-1:0] ISSUE_ADDRESS,
    input  logic [ADDR_WIDTH-1:0] OUT1_ADDRESS,
    input  logic [ADDR_WIDTH-1:0] OUT2_ADDRESS,
    input  logic [ADDR_WIDTH-1:0] OUT3_ADDRESS,
    output logic [DATA_WIDTH-1:0] DATA_OUT1,
    output logic [DATA_WIDTH-1:0] DATA_OUT2,
    output logic [DATA_WIDTH-1:0] DATA_OUT3,
    output logic                  BUSY1,
    output logic                  BUSY2,
    output logic                  BUSY3,
    output logic                  BUSY_ANY,
    input  logic                  FFLAGS_CLR,
    output logic [FLAG_WIDTH-1:0] FFLAGS
);
    localparam int REG_COUNT = 2**ADDR_WIDTH;
    localparam int NUM_RD    = 3;

    logic [REG_COUNT-1:0][DATA_WIDTH-1:0] regs_q, regs_d;
    logic [REG_COUNT-1:0]                 busy_q, busy_d;
    logic [FLAG_WIDTH-1:0]                fflags_q, fflags_d;

    logic [NUM_RD-1:0][ADDR_WIDTH-1:0]    rd_addr;
    logic [NUM_RD-1:0][DATA_WIDTH-1:0]    rd_data;
    logic [NUM_RD-1:0]                    rd_busy;

    always_comb begin
        regs_d = regs_q;
        // Port A is applied last so it wins an address collision.
        if (WRITE_EN_B)
            regs_d[IN_ADDRESS_B] = DATA_IN_B;
        if (WRITE_EN_A)
            regs_d[IN_ADDRESS_A] = DATA_IN_A;
    end

    always_comb begin
        busy_d = busy_q;
        // Issue applied after retire: a fresh op on the same register keeps it busy.
        if (WRITE_EN_B)
            busy_d[IN_ADDRESS_B] = 1'b0;
        if (ISSUE_EN)
            busy_d[ISSUE_ADDRESS] = 1'b1;
    end

    always_comb begin
        fflags_d = FFLAGS_CLR ? '0 : fflags_q;
        if (WRITE_EN_A)
            fflags_d = fflags_d | FLAGS_A;
        if (WRITE_EN_B)
            fflags_d = fflags_d | FLAGS_B;
    end

    always_ff @(negedge CLK) begin
        if (RESET) begin
            regs_q   <= '0;
            busy_q   <= '0;
            fflags_q <= '0;
        end else begin
            regs_q   <= regs_d;
            busy_q   <= busy_d;
            fflags_q <= fflags_d;
        end
    end

    assign rd_addr = {OUT3_ADDRESS, OUT2_ADDRESS, OUT1_ADDRESS};

    generate
        for (genvar p = 0; p < NUM_RD; p++) begin : g_rd
            f_reg_file_sb_rdport #(
                .DATA_WIDTH (DATA_WIDTH),
                .ADDR_WIDTH (ADDR_WIDTH),
                .REG_COUNT  (REG_COUNT),
                .BYPASS     (BYPASS)
            ) u_rdport (
                .rd_addr_i (rd_addr[p]),
                .regs_i    (regs_q),
                .busy_i    (busy_q),
                .we_a_i    (WRITE_EN_A),
                .addr_a_i  (IN_ADDRESS_A),
                .data_a_i  (DATA_IN_A),
                .we_b_i    (WRITE_EN_B),
                .addr_b_i  (IN_ADDRESS_B),
                .data_b_i  (DATA_IN_B),
                .data_o    (rd_data[p]),
                .busy_o    (rd_busy[p])
            );
        end
    endgenerate

    assign DATA_OUT1 = rd_data[0];
    assign DATA_OUT2 = rd_data[1];
    assign DATA_OUT3 = rd_data[2];
    assign BUSY1     = rd_busy[0];
    assign BUSY2     = rd_busy[1];
    assign BUSY3     = rd_busy[2];
    assign BUSY_ANY  = |busy_q;
    assign FFLAGS    = fflags_q;
endmodule

// File: tb/tb_f_reg_file_sb.sv
// Directed bench: a forwarding and a non-forwarding register file driven by the
// same stimulus; state changes on the falling edge, inputs driven 1ns after it.

module tb_f_reg_file_sb;
    logic        CLK = 1'b1;
    logic        RESET, WRITE_EN_A, WRITE_EN_B, ISSUE_EN, FFLAGS_CLR;
    logic [4:0]  IN_ADDRESS_A, IN_ADDRESS_B, ISSUE_ADDRESS;
    logic [4:0]  OUT1_ADDRESS, OUT2_ADDRESS, OUT3_ADDRESS;
    logic [31:0] DATA_IN_A, DATA_IN_B;
    logic [4:0]  FLAGS_A, FLAGS_B;

    logic [31:0] d1, d2, d3, n1, n2, n3;
    logic        b1, b2, b3, bany, nb1, nb2, nb3, nbany;
    logic [4:0]  ff, nff;

    int n_cmp = 0;
    int n_err = 0;

    always #5 CLK = ~CLK;

    f_reg_file_sb #(.BYPASS(1'b1)) dut (
        .CLK(CLK), .RESET(RESET),
        .WRITE_EN_A(WRITE_EN_A), .IN_ADDRESS_A(IN_ADDRESS_A), .DATA_IN_A(DATA_IN_A), .FLAGS_A(FLAGS_A),
        .WRITE_EN_B(WRITE_EN_B), .IN_ADDRESS_B(IN_ADDRESS_B), .DATA_IN_B(DATA_IN_B), .FLAGS_B(FLAGS_B),
        .ISSUE_EN(ISSUE_EN), .ISSUE_ADDRESS(ISSUE_ADDRESS),
        .OUT1_ADDRESS(OUT1_ADDRESS), .OUT2_ADDRESS(OUT2_ADDRESS), .OUT3_ADDRESS(OUT3_ADDRESS),
        .DATA_OUT1(d1), .DATA_OUT2(d2), .DATA_OUT3(d3),
        .BUSY1(b1), .BUSY2(b2), .BUSY3(b3), .BUSY_ANY(bany),
        .FFLAGS_CLR(FFLAGS_CLR), .FFLAGS(ff)
    );

    f_reg_file_sb #(.BYPASS(1'b0)) dut_nb (
        .CLK(CLK), .RESET(RESET),
        .WRITE_EN_A(WRITE_EN_A), .IN_ADDRESS_A(IN_ADDRESS_A), .DATA_IN_A(DATA_IN_A), .FLAGS_A(FLAGS_A),
        .WRITE_EN_B(WRITE_EN_B), .IN_ADDRESS_B(IN_ADDRESS_B), .DATA_IN_B(DATA_IN_B), .FLAGS_B(FLAGS_B),
        .ISSUE_EN(ISSUE_EN), .ISSUE_ADDRESS(ISSUE_ADDRESS),
        .OUT1_ADDRESS(OUT1_ADDRESS), .OUT2_ADDRESS(OUT2_ADDRESS), .OUT3_ADDRESS(OUT3_ADDRESS),
        .DATA_OUT1(n1), .DATA_OUT2(n2), .DATA_OUT3(n3),
        .BUSY1(nb1), .BUSY2(nb2), .BUSY3(nb3), .BUSY_ANY(nbany),
        .FFLAGS_CLR(FFLAGS_CLR), .FFLAGS(nff)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
        end
    endtask

    task automatic idle();
        RESET = 1'b0; WRITE_EN_A = 1'b0; WRITE_EN_B = 1'b0; ISSUE_EN = 1'b0; FFLAGS_CLR = 1'b0;
        IN_ADDRESS_A = '0; IN_ADDRESS_B = '0; ISSUE_ADDRESS = '0;
        DATA_IN_A = '0; DATA_IN_B = '0; FLAGS_A = '0; FLAGS_B = '0;
    endtask

    // Advance through one falling edge and settle 1ns past it.
    task automatic tick();
        @(negedge CLK);
        #1;
    endtask

    initial begin
        idle();
        OUT1_ADDRESS = 5'd0; OUT2_ADDRESS = 5'd0; OUT3_ADDRESS = 5'd0;
        RESET = 1'b1;
        tick();
        chk("rst_data1", d1, 32'h0);
        chk("rst_fflags", {27'h0, ff}, 32'h0);
        chk("rst_busy_any", {31'h0, bany}, 32'h0);

        // Port A write f3, visible pre-edge only with forwarding
        idle();
        WRITE_EN_A = 1'b1; IN_ADDRESS_A = 5'd3; DATA_IN_A = 32'h3F800000; OUT1_ADDRESS = 5'd3;
        #1;
        chk("a_fwd_pre", d1, 32'h3F800000);
        chk("a_nofwd_pre", n1, 32'h0);
        tick();
        chk("a_post", d1, 32'h3F800000);

        // Reset wipes it again
        idle();
        RESET = 1'b1;
        tick();
        chk("rst2_data1", d1, 32'h0);
        chk("rst2_fflags", {27'h0, ff}, 32'h0);
        chk("rst2_busy_any", {31'h0, bany}, 32'h0);

        // Issue f7, then port B retires it
        idle();
        ISSUE_EN = 1'b1; ISSUE_ADDRESS = 5'd7; OUT2_ADDRESS = 5'd7;
        tick();
        chk("issue_busy2", {31'h0, b2}, 32'h1);
        chk("issue_busy_any", {31'h0, bany}, 32'h1);
        idle();
        WRITE_EN_B = 1'b1; IN_ADDRESS_B = 5'd7; DATA_IN_B = 32'h40490FDB;
        #1;
        chk("b_fwd_data2", d2, 32'h40490FDB);
        chk("b_fwd_busy2", {31'h0, b2}, 32'h0);
        chk("b_nofwd_busy2", {31'h0, nb2}, 32'h1);
        chk("b_nofwd_data2", n2, 32'h0);
        chk("b_pre_busy_any", {31'h0, bany}, 32'h1);
        tick();
        chk("b_post_busy_any", {31'h0, bany}, 32'h0);
        chk("b_post_data2", d2, 32'h40490FDB);

        // Collision on busy f5: A data wins, busy still cleared
        idle();
        ISSUE_EN = 1'b1; ISSUE_ADDRESS = 5'd5;
        tick();
        idle();
        WRITE_EN_A = 1'b1; IN_ADDRESS_A = 5'd5; DATA_IN_A = 32'h11111111;
        WRITE_EN_B = 1'b1; IN_ADDRESS_B = 5'd5; DATA_IN_B = 32'h22222222;
        OUT3_ADDRESS = 5'd5;
        #1;
        chk("coll_fwd_data3", d3, 32'h11111111);
        chk("coll_fwd_busy3", {31'h0, b3}, 32'h0);
        tick();
        chk("coll_post_data3", d3, 32'h11111111);
        chk("coll_post_nofwd3", n3, 32'h11111111);
        chk("coll_post_busy_any", {31'h0, bany}, 32'h0);

        // Issue and retire f9 on the same edge: data lands, busy stays set
        idle();
        ISSUE_EN = 1'b1; ISSUE_ADDRESS = 5'd9;
        WRITE_EN_B = 1'b1; IN_ADDRESS_B = 5'd9; DATA_IN_B = 32'hCAFEF00D;
        OUT1_ADDRESS = 5'd9;
        tick();
        idle();
        #1;
        chk("setclr_data1", d1, 32'hCAFEF00D);
        chk("setclr_busy1", {31'h0, b1}, 32'h1);
        chk("setclr_busy_any", {31'h0, bany}, 32'h1);

        // Accrued flags
        idle();
        WRITE_EN_A = 1'b1; IN_ADDRESS_A = 5'd10; DATA_IN_A = 32'h1; FLAGS_A = 5'b00001;
        tick();
        chk("ff_a", {27'h0, ff}, 32'h01);
        idle();
        WRITE_EN_B = 1'b1; IN_ADDRESS_B = 5'd9; DATA_IN_B = 32'h2; FLAGS_B = 5'b10000;
        tick();
        chk("ff_ab", {27'h0, ff}, 32'h11);
        chk("ff_b_busy_any", {31'h0, bany}, 32'h0);
        idle();
        FFLAGS_CLR = 1'b1; WRITE_EN_A = 1'b1; IN_ADDRESS_A = 5'd10; FLAGS_A = 5'b00100;
        tick();
        chk("ff_clr_new", {27'h0, ff}, 32'h04);
        idle();
        FLAGS_A = 5'b11111; FLAGS_B = 5'b11111;
        tick();
        chk("ff_gated", {27'h0, ff}, 32'h04);
        chk("ff_gated_nb", {27'h0, nff}, 32'h04);

        // f0 is an ordinary register
        idle();
        WRITE_EN_A = 1'b1; IN_ADDRESS_A = 5'd0; DATA_IN_A = 32'h12345678; OUT2_ADDRESS = 5'd0;
        tick();
        chk("f0_write", d2, 32'h12345678);

        // Non-forwarding build shows old value until the edge
        idle();
        WRITE_EN_A = 1'b1; IN_ADDRESS_A = 5'd2; DATA_IN_A = 32'hDEADBEEF; OUT1_ADDRESS = 5'd2;
        #1;
        chk("nofwd_pre", n1, 32'h0);
        chk("fwd_pre", d1, 32'hDEADBEEF);
        tick();
        chk("nofwd_post", n1, 32'hDEADBEEF);

        // Reset during an in-flight op drops busy; later B write is a plain write
        idle();
        ISSUE_EN = 1'b1; ISSUE_ADDRESS = 5'd4; OUT3_ADDRESS = 5'd4;
        tick();
        chk("mid_busy3", {31'h0, b3}, 32'h1);
        idle();
        RESET = 1'b1;
        tick();
        chk("mid_rst_busy_any", {31'h0, bany}, 32'h0);
        chk("mid_rst_f0", d2, 32'h0);
        idle();
        WRITE_EN_B = 1'b1; IN_ADDRESS_B = 5'd4; DATA_IN_B = 32'h00000055;
        tick();
        idle();
        #1;
        chk("late_b_data3", d3, 32'h00000055);
        chk("late_b_busy3", {31'h0, b3}, 32'h0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule

// File: doc/f_reg_file_sb.md
Name: f_reg_file_sb

Overview:
Parametrised floating-point register file for the CPU's F-extension datapath. It has two write ports: port A for single-cycle FPU and load writeback, and port B for long-latency divide/sqrt writeback. It has three asynchronous read ports with optional write-through bypass, a per-register busy scoreboard for in-flight long-latency ops, and an accrued exception-flag register (fflags). It sits between the decode/issue stage and the FPU writeback mux.

Parameters:
DATA_WIDTH, 32, width of each register and data port
ADDR_WIDTH, 5, register address width; REG_COUNT = 2**ADDR_WIDTH
BYPASS, 1, 1 = same-edge write data forwarded to read ports; 0 = no forwarding
FLAG_WIDTH, 5, width of exception flags (NV,DZ,OF,UF,NX)

Ports:
CLK  in  1  clock; all state updates on falling edge
RESET  in  1  synchronous active-high reset, sampled on falling edge of CLK
WRITE_EN_A  in  1  port A write enable
IN_ADDRESS_A  in  ADDR_WIDTH  port A write address
DATA_IN_A  in  DATA_WIDTH  port A write data
FLAGS_A  in  FLAG_WIDTH  exception flags accompanying port A write
WRITE_EN_B  in  1  port B (long-latency) write enable
IN_ADDRESS_B  in  ADDR_WIDTH  port B write address
DATA_IN_B  in  DATA_WIDTH  port B write data
FLAGS_B  in  FLAG_WIDTH  exception flags accompanying port B write
ISSUE_EN  in  1  long-latency op issued; mark destination busy
ISSUE_ADDRESS  in  ADDR_WIDTH  destination of issued op
OUT1_ADDRESS, OUT2_ADDRESS, OUT3_ADDRESS  in  ADDR_WIDTH each  read addresses
DATA_OUT1, DATA_OUT2, DATA_OUT3  out  DATA_WIDTH each  read data
BUSY1, BUSY2, BUSY3  out  1 each  addressed register has a pending port-B write
BUSY_ANY  out  1  at least one busy bit set
FFLAGS_CLR  in  1  clear accrued flags
FFLAGS  out  FLAG_WIDTH  accrued exception flags

Behaviour:
- Reset: on a falling edge with RESET=1, all REG_COUNT registers, all busy bits and FFLAGS go to 0. All other inputs are ignored that edge. Outputs read 0 and BUSY*=0 from then on. Reset mid long-latency op drops the busy bit; a later port-B write is still accepted as a normal write.
- Writes: registered on falling edge when RESET=0. Port A writes if WRITE_EN_A; port B writes if WRITE_EN_B.
- Write collision (same address, both enables): port A data is stored, port B data is discarded. Port B still clears the busy bit.
- Reads: combinational from the register array.
- Bypass (BYPASS=1): if OUTn_ADDRESS matches an enabled write address in the current cycle, DATA_OUTn shows the incoming data, with port A taking priority over port B.
- Bypass (BYPASS=0): DATA_OUTn shows the old value until after the edge.
- Scoreboard:
  - ISSUE_EN sets busy[ISSUE_ADDRESS] on the edge.
  - WRITE_EN_B clears busy[IN_ADDRESS_B] on the edge.
  - Port A never touches busy bits.
  - Set and clear on the same address in the same edge: set wins (new op issued).
  - Issue to an already-busy register: stays busy, no error.
- BUSYn: busy[OUTn_ADDRESS]. If BYPASS=1 and WRITE_EN_B targets OUTn_ADDRESS in the same cycle, BUSYn is forced to 0 (data is forwarded). BUSY_ANY is the OR of all busy bits (registered state, no bypass masking).
- FFLAGS: on each edge, next = (FFLAGS_CLR ? 0 : FFLAGS) | (WRITE_EN_A ? FLAGS_A : 0) | (WRITE_EN_B ? FLAGS_B : 0). Clear plus new flags on the same edge leaves only the new flags. FLAGS_* are ignored when the matching enable is low.
- Register 0 is a normal writable register (FP file has no hard zero).
- Latency: write visible on reads 0 cycles with bypass, otherwise immediately after the falling edge. Busy set/clear is visible after the edge.

Test Plan:
- Reset, then write f3=0x3F800000 via A, read OUT1=3 -> DATA_OUT1=0x3F800000; assert RESET one edge -> DATA_OUT1=0, FFLAGS=0, BUSY_ANY=0.
- ISSUE f7, read OUT2=7 -> BUSY2=1. Next cycle port B writes f7=0x40490FDB with BYPASS=1 -> DATA_OUT2=0x40490FDB and BUSY2=0 same cycle; after edge BUSY_ANY=0.
- Same edge: A writes f5=0x11111111, B writes f5=0x22222222 (f5 busy) -> f5=0x11111111, busy[5]=0; with BYPASS=1, DATA_OUT3 addressing f5 shows 0x11111111 pre-edge.
- Same edge: ISSUE f9 and port B write f9 -> f9 holds B data, busy[9]=1.
- FLAGS_A=0b00001 then FLAGS_B=0b10000 -> FFLAGS=0b10001. FFLAGS_CLR with FLAGS_A=0b00100 -> FFLAGS=0b00100. FLAGS_A=0b11111 with WRITE_EN_A=0 -> no change.
- BYPASS=0 build: A writes f2=0xDEADBEEF, OUT1=2 -> pre-edge old value 0, post-edge 0xDEADBEEF.
